// File: rtl/mtr_drv_pwm.sv
// Purpose: signed wheel-speed commands -> dead-time protected complementary H-bridge PWM (11-bit, 2048-clock period).
// Latency: speed sampled at the 2047->0 boundary; output edges lag the raw compare by 1 clock plus DEAD_TIME.
// Backpressure: none; free-running counter, inputs are sampled once per period. SPD_SLEW_EN enables per-period duty slewing.
module mtr_drv_pwm #(
    parameter int DEAD_TIME = 6,
    parameter int SLEW_STEP = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtr_en,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    output logic        lftPWM1,
    output logic        lftPWM2,
    output logic        rghtPWM1,
    output logic        rghtPWM2,
    output logic        prd_done
);

    localparam logic [5:0]  DT       = 6'(DEAD_TIME);
    localparam logic [10:0] DUTY_MID = 11'h400;

`ifdef SPD_SLEW_EN
    localparam logic [10:0] STEP_LIM = 11'(SLEW_STEP);
`else
    // All-ones step exceeds any possible duty difference, so the latch jumps straight to target.
    localparam logic [10:0] STEP_LIM = 11'h7FF | 11'(SLEW_STEP);
`endif

    // Channel index 0 = left wheel, 1 = right wheel.
    logic [10:0]      cnt;
    logic [1:0][10:0] duty;
    logic [1:0][10:0] tgt;
    logic [1:0]       raw;
    logic [1:0]       raw_q;
    logic [1:0][5:0]  dcnt;
    logic [1:0][5:0]  dcnt_nxt;
    logic [1:0]       pwm1;
    logic [1:0]       pwm2;

    // Clip a signed speed to +/-1023 and bias it around mid-scale, giving a duty of 1..2047.
    function automatic logic [10:0] duty_tgt(input logic [11:0] spd);
        logic signed [11:0] s;
        logic signed [11:0] sum;
        s = $signed(spd);
        if (s > 12'sd1023) begin
            s = 12'sd1023;
        end else if (s < -12'sd1023) begin
            s = -12'sd1023;
        end
        sum = 12'sd1024 + s;
        return sum[10:0];
    endfunction

    // Move the latched duty toward the target by at most STEP_LIM counts.
    function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] tgt_v);
        logic [10:0] r;
        if (tgt_v > cur) begin
            r = ((tgt_v - cur) > STEP_LIM) ? (cur + STEP_LIM) : tgt_v;
        end else begin
            r = ((cur - tgt_v) > STEP_LIM) ? (cur - STEP_LIM) : tgt_v;
        end
        return r;
    endfunction

    // Saturated duty targets from the live speed commands.
    always_comb begin
        tgt    = '0;
        tgt[0] = duty_tgt(lft_spd);
        tgt[1] = duty_tgt(rght_spd);
    end

    // Raw compare and next dead-time count; a raw transition restarts the dead-time window.
    always_comb begin
        raw      = '0;
        dcnt_nxt = '0;
        for (int i = 0; i < 2; i++) begin
            raw[i] = (cnt < duty[i]);
            if (raw[i] != raw_q[i]) begin
                dcnt_nxt[i] = '0;
            end else if (dcnt[i] >= DT) begin
                dcnt_nxt[i] = DT;
            end else begin
                dcnt_nxt[i] = dcnt[i] + 6'd1;
            end
        end
    end

    // Free-running period counter; prd_done is registered so it is high while cnt == 2047.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_done <= 1'b0;
        end else begin
            cnt      <= cnt + 11'd1;
            prd_done <= (cnt == 11'h7FE);
        end
    end

    // Latch duty only at the period boundary so a period never sees a mid-period change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= {DUTY_MID, DUTY_MID};
        end else if (cnt == 11'h7FF) begin
            for (int i = 0; i < 2; i++) begin
                duty[i] <= slew(duty[i], tgt[i]);
            end
        end
    end

    // Dead-time counters and registered drive lines; coasting clears the counters and forces lines low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
            dcnt  <= '0;
            pwm1  <= '0;
            pwm2  <= '0;
        end else begin
            raw_q <= raw;
            for (int i = 0; i < 2; i++) begin
                if (mtr_en) begin
                    dcnt[i] <= dcnt_nxt[i];
                    pwm1[i] <= raw[i] & (dcnt_nxt[i] >= DT);
                    pwm2[i] <= ~raw[i] & (dcnt_nxt[i] >= DT);
                end else begin
                    dcnt[i] <= '0;
                    pwm1[i] <= 1'b0;
                    pwm2[i] <= 1'b0;
                end
            end
        end
    end

    assign lftPWM1  = pwm1[0];
    assign lftPWM2  = pwm2[0];
    assign rghtPWM1 = pwm1[1];
    assign rghtPWM2 = pwm2[1];

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: per-period high-time counts from a vector table, plus coast and async-reset sequences.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge.
// A background monitor tracks overlap and dead-time gaps on each bridge pair.
module tb_mtr_drv_pwm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mtr_en;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        lftPWM1;
    logic        lftPWM2;
    logic        rghtPWM1;
    logic        rghtPWM2;
    logic        prd_done;

    mtr_drv_pwm #(.DEAD_TIME(6), .SLEW_STEP(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mtr_en   (mtr_en),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2),
        .prd_done (prd_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        int          chg_at;
        logic [11:0] chg_val;
        int          e_l1;
        int          e_l2;
        int          e_r1;
        int          e_r2;
    } vec_t;

    vec_t vecs[$];

    int n_total  = 0;
    int n_pass   = 0;
    int ovl_n    = 0;
    int gap_viol = 0;
    int last_l   = 0;
    int last_r   = 0;
    int run_l    = 0;
    int run_r    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] l, input logic [11:0] r, input int ca,
                                input logic [11:0] cv, input int a, input int b, input int c, input int d);
        vec_t v;
        v.lft = l; v.rght = r; v.chg_at = ca; v.chg_val = cv;
        v.e_l1 = a; v.e_l2 = b; v.e_r1 = c; v.e_r2 = d;
        return v;
    endfunction

    // One monitor step for a bridge pair: run = both-low cycles since the last high line.
    task automatic pair_step(input logic p1, input logic p2, inout int last, inout int run);
        if (p1 && p2) begin
            ovl_n++;
        end else if (p1) begin
            if (last == 2 && run < 6) gap_viol++;
            last = 1;
            run  = 0;
        end else if (p2) begin
            if (last == 1 && run < 6) gap_viol++;
            last = 2;
            run  = 0;
        end else begin
            run++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_l = 0; run_l = 0; last_r = 0; run_r = 0;
        end else begin
            pair_step(lftPWM1, lftPWM2, last_l, run_l);
            pair_step(rghtPWM1, rghtPWM2, last_r, run_r);
        end
    end

    // Wait (bounded) for the negedge sample where prd_done is high, i.e. cnt == 2047.
    task automatic wait_prd();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!prd_done && w < 3000);
        check("prd_wait", int'(prd_done), 1);
    endtask

    // Count high samples over cnt = 1..2047 then next 0; index k is cnt k+1.
    task automatic window(input int chg_at, input logic [11:0] chg_val,
                          output int c0, output int c1, output int c2, output int c3,
                          output int pidx, output int pn);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; pidx = -1; pn = 0;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (lftPWM1)  c0++;
            if (lftPWM2)  c1++;
            if (rghtPWM1) c2++;
            if (rghtPWM2) c3++;
            if (prd_done) begin
                pn++;
                pidx = k;
            end
            if (k + 1 == chg_at) lft_spd = chg_val;
        end
    endtask

    initial begin
        int c0, c1, c2, c3, pidx, pn;

        rst_n    = 1'b0;
        mtr_en   = 1'b1;
        lft_spd  = 12'h000;
        rght_spd = 12'h000;

`ifdef SPD_SLEW_EN
        vecs.push_back(mk(12'h000, 12'h000, -1, 12'h000, 1018, 1018, 1018, 1018));
        vecs.push_back(mk(12'h3FF, 12'h000, -1, 12'h000, 1050,  986, 1018, 1018));
        vecs.push_back(mk(12'h3FF, 12'h000, -1, 12'h000, 1082,  954, 1018, 1018));
`else
        vecs.push_back(mk(12'h000, 12'h000, -1, 12'h000, 1018, 1018, 1018, 1018));
        vecs.push_back(mk(12'h1F4, 12'hE0C, -1, 12'h000, 1518,  518,  518, 1518));
        vecs.push_back(mk(12'h7FF, 12'h800, -1, 12'h000, 2041,    0,    0, 2041));
        vecs.push_back(mk(12'h000, 12'h000, 100, 12'h12C, 1018, 1018, 1018, 1018));
        vecs.push_back(mk(12'h12C, 12'h000, -1, 12'h000, 1318,  718, 1018, 1018));
        vecs.push_back(mk(12'hC07, 12'hC06, -1, 12'h000,    1, 2035,    0, 2036));
        vecs.push_back(mk(12'hC00, 12'h400, -1, 12'h000,    0, 2041, 2041,    0));
        vecs.push_back(mk(12'h000, 12'h000, -1, 12'h000, 1018, 1018, 1018, 1018));
        vecs.push_back(mk(12'h3FF, 12'h000, -1, 12'h000, 2041,    0, 1018, 1018));
`endif

        repeat (3) @(negedge clk);
        check("rst_pwm", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        check("rst_prd_done", int'(prd_done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            lft_spd  = vecs[i].lft;
            rght_spd = vecs[i].rght;
            wait_prd();
            @(negedge clk);
            window(vecs[i].chg_at, vecs[i].chg_val, c0, c1, c2, c3, pidx, pn);
            check($sformatf("v%0d_lftPWM1", i),  c0, vecs[i].e_l1);
            check($sformatf("v%0d_lftPWM2", i),  c1, vecs[i].e_l2);
            check($sformatf("v%0d_rghtPWM1", i), c2, vecs[i].e_r1);
            check($sformatf("v%0d_rghtPWM2", i), c3, vecs[i].e_r2);
            check($sformatf("v%0d_prd_pos", i),  pidx, 2046);
            check($sformatf("v%0d_prd_cnt", i),  pn, 1);
        end

        // Coast mid-period, then resume after the dead time.
        lft_spd  = 12'h000;
        rght_spd = 12'h000;
        wait_prd();
        repeat (200) @(negedge clk);
        check("pre_coast", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 4'b1010);
        mtr_en = 1'b0;
        @(negedge clk);
        check("coast_next_clk", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        repeat (10) @(negedge clk);
        check("coast_hold", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        mtr_en = 1'b1;
        repeat (5) @(negedge clk);
        check("resume_5clk", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        @(negedge clk);
        check("resume_6clk", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 4'b1010);

        // Asynchronous reset while PWM1 is high; first period afterwards uses mid-scale duty.
        @(negedge clk);
        check("pre_reset", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 4'b1010);
        lft_spd = 12'h1F4;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_pwm", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        window(-1, 12'h000, c0, c1, c2, c3, pidx, pn);
        check("post_rst_lftPWM1",  c0, 1018);
        check("post_rst_lftPWM2",  c1, 1018);
        check("post_rst_rghtPWM1", c2, 1018);
        check("post_rst_rghtPWM2", c3, 1018);
        check("post_rst_prd_pos",  pidx, 2046);
        check("post_rst_prd_cnt",  pn, 1);

        check("no_overlap", ovl_n, 0);
        check("dead_gap",   gap_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mtr_drv_pwm.md
Name: mtr_drv_pwm

Overview:
- Motor drive PWM stage for the Knight: converts signed left/right wheel speed commands into the four complementary H-bridge drive lines lftPWM1/2 and rghtPWM1/2.
- Each line is an 11-bit PWM with a 2048-clock period and dead time.
- Sits between the navigation/PID logic and the motor pins.
- Output is what the board physics model measures: duty difference PWM1 − PWM2 equals drive magnitude and sign.

Parameters:
- DEAD_TIME, 6: clocks both lines of a pair are held low around every complementary transition (legal 1..63).
- SLEW_STEP, 32: max duty change per PWM period when SPD_SLEW_EN is defined.

Ports:
- clk  in  1  50MHz system clock
- rst_n  in  1  asynchronous active-low reset
- mtr_en  in  1  1 = drive; 0 = coast (all four outputs low)
- lft_spd  in  12  signed left wheel speed command
- rght_spd  in  12  signed right wheel speed command
- lftPWM1  out  1  left bridge high side, forward
- lftPWM2  out  1  left bridge low side, reverse
- rghtPWM1  out  1  right bridge high side, forward
- rghtPWM2  out  1  right bridge low side, reverse
- prd_done  out  1  one-clock pulse on the last clock of each PWM period (cnt == 2047)

Behaviour:

Reset values:
- cnt = 0.
- lft_duty = rght_duty = 11'h400 (zero speed).
- All four PWM outputs = 0.
- prd_done = 0.
- Raw/dead-time state is cleared.

Period counter:
- cnt is an 11-bit free-running up-counter that wraps 2047 → 0.
- prd_done is registered and equals 1 in the clock cycle where cnt == 2047.

Saturation:
- spd_sat = clip(spd, −1023, +1023).
- Examples: −2048 → −1023; 2047 → +1023.
- duty target = 11'h400 + spd_sat, so the range is 1..2047.

Duty latching:
- Target duty is sampled into lft_duty/rght_duty only on the edge where cnt goes 2047 → 0.
- Speed changes mid-period have no effect until the next period.
- The latched duty is used for the whole following period, so there are no glitch pulses.

Raw compare:
- raw = (cnt < duty), evaluated per channel.

Dead time, per channel:
- A 6-bit counter dcnt clears on every raw transition and otherwise increments, saturating at DEAD_TIME.
- PWM1 <= raw & (dcnt >= DEAD_TIME).
- PWM2 <= ~raw & (dcnt >= DEAD_TIME).
- PWM1 and PWM2 are never simultaneously 1, and both are low for DEAD_TIME clocks after each edge.
- Per period: PWM1 high count = max(duty − DEAD_TIME, 0); PWM2 high count = max(2048 − duty − DEAD_TIME, 0).
- Net PWM1 − PWM2 = 2·spd_sat.
- If duty ≤ DEAD_TIME, PWM1 never asserts; the symmetric rule applies to PWM2.

Coast:
- mtr_en = 0 forces all four outputs to 0 from the next clock edge.
- cnt and the duty latches keep running.
- When mtr_en returns to 1, outputs resume after DEAD_TIME clocks of the current raw level; dcnt is cleared while disabled.

Reset mid-period:
- Asynchronous; outputs drop to 0 immediately.
- After release, the first period starts at cnt = 0 with duty 11'h400.

Latency:
- A speed change presented at cnt = k first affects the outputs in the period beginning 2048 − k clocks later.
- Output edges lag the raw compare by 1 clock plus dead time.

Optional Feature:
- Macro: SPD_SLEW_EN.
- Defined: at each period boundary, each channel's latched duty moves toward the target by at most SLEW_STEP counts; any remainder carries into later periods. Example: 0x400 → 0x7FF takes 32 periods at step 32.
- Not defined: the latched duty jumps directly to the target at the boundary.
- Reset behaviour is identical in both builds.

Test Plan:
1. Reset, mtr_en = 1, lft_spd = rght_spd = 0, DEAD_TIME = 6 → every 2048-clock period each PWM1 and PWM2 is high 1018 clocks; prd_done pulses every 2048 clocks.
2. lft_spd = +500, rght_spd = −500 → from the next period: lftPWM1 = 1518, lftPWM2 = 518; rghtPWM1 = 518, rghtPWM2 = 1518 clocks high.
3. lft_spd = 12'h7FF, rght_spd = 12'h800 → saturate: lftPWM1 = 2041, lftPWM2 = 0; rghtPWM1 = 0, rghtPWM2 = 2041. A continuous checker confirms PWM1 & PWM2 is never true and every gap is ≥ 6 clocks.
4. Change lft_spd from 0 to +300 at cnt = 100 → current period still 1018/1018; following period 1318/718.
5. Drop mtr_en mid-period → all outputs 0 on the next clock. Reassert → outputs resume 6 clocks later. Assert rst_n = 0 while PWM1 is high → outputs 0 asynchronously; after release, cnt restarts at 0 with duty 0x400.
6. With SPD_SLEW_EN: step lft_spd 0 → +1023 → latched duty advances 32 per period, reaching 0x7FF on the 32nd boundary. Without SPD_SLEW_EN: 0x7FF at the first boundary.
